// File: rtl/canvas_cmd_issuer_pkg.sv
// ----------------------------------------------------------------------------
// canvas_cmd_issuer_pkg
//   Shared definitions for the canvas command issuer. The canvas decoder uses
//   the same FSM state encodings and default command width.
//   Contents:
//     state_t        issuer FSM states (ST_IDLE / ST_STROBE / ST_GAP)
//     CMD_W_DEFAULT  default width of one command word
//     GAP_CNT_W      width of the inter-strobe gap counter (GAP_CYCLES <= 255)
// ----------------------------------------------------------------------------
package canvas_cmd_issuer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    localparam int CMD_W_DEFAULT = 32;
    localparam int GAP_CNT_W     = 8;

endpackage : canvas_cmd_issuer_pkg

// File: rtl/canvas_cmd_issuer_if.sv
// ----------------------------------------------------------------------------
// canvas_cmd_issuer_if
//   Valid/ready push channel between a command producer and the issuer.
//   Signals:
//     valid  producer has a command word on data
//     ready  issuer FIFO can accept a word this cycle
//     data   command word
//   Modports:
//     master  producer side (drives valid/data, observes ready)
//     slave   issuer side   (observes valid/data, drives ready)
// ----------------------------------------------------------------------------
interface canvas_cmd_issuer_if
    import canvas_cmd_issuer_pkg::*;
#(
    parameter int DATA_W = CMD_W_DEFAULT
) ();

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface : canvas_cmd_issuer_if

// File: rtl/canvas_cmd_issuer_fifo.sv
// ----------------------------------------------------------------------------
// canvas_cmd_issuer_fifo  (the cmd_fifo sub-block of the issuer)
//   Synchronous FIFO with write, read and flush. Storage is an inferred RAM;
//   the head word is read combinationally so the issuer can capture it on the
//   same edge that pops it. Full/empty come from the occupancy count, so the
//   pointers may be equal in both cases.
//   Ports:
//     i_clk     clock, rising edge
//     i_rst     synchronous reset, active-high (clears pointers and level)
//     i_wr      write request; ignored while full or flushing
//     i_data    word to write
//     i_rd      read (pop) request; ignored while empty
//     i_flush   drop every queued word; a same-cycle write is dropped too
//     o_head    word at the read pointer
//     o_level   number of queued words, 0..2**DEPTH_LOG2
//     o_full    level == 2**DEPTH_LOG2
//     o_empty   level == 0
// ----------------------------------------------------------------------------
module canvas_cmd_issuer_fifo #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr,
    input  logic [DATA_W-1:0]     i_data,
    input  logic                  i_rd,
    input  logic                  i_flush,
    output logic [DATA_W-1:0]     o_head,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_level == LVL_FULL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_head  = r_mem[r_rd_ptr];

    // A flush wins over a same-cycle write so the flushed queue stays empty.
    assign w_push = i_wr & ~o_full & ~i_flush;
    assign w_pop  = i_rd & ~o_empty;

    // NOTE: sequential state is updated with <= so every register samples the
    // pre-edge values of its neighbours; = here would create order-dependent races.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            // The write pointer does not move (push is suppressed), so snapping
            // the read pointer onto it empties the queue even if a pop is in flight.
            r_rd_ptr <= r_wr_ptr;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the level count alone decides which
    // entries are meaningful, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule : canvas_cmd_issuer_fifo

// File: rtl/canvas_cmd_issuer.sv
// ----------------------------------------------------------------------------
// canvas_cmd_issuer
//   Initiator side of the canvas command interface. Command words pushed by a
//   producer are queued in a FIFO and issued one per single-cycle strobe, with
//   at least GAP_CYCLES low cycles after each strobe. With BLANK_ONLY=1 a new
//   strobe starts only while the scan is blanked; a strobe already started
//   always completes together with its gap.
//   Ports:
//     i_pix_clk   pixel clock, rising edge
//     i_rst       synchronous reset, active-high
//     s_push      producer push channel (valid / ready / data)
//     i_blank     1 = display outside the active area
//     i_flush     discard every queued, unissued word
//     o_cmd_clk   one-cycle command strobe to the canvas
//     o_cmd_data  command word; valid with o_cmd_clk, held until the next strobe
//     o_level     number of queued words
//     o_busy      words queued or a strobe/gap in progress
// ----------------------------------------------------------------------------
module canvas_cmd_issuer
    import canvas_cmd_issuer_pkg::*;
#(
    parameter int DATA_W     = CMD_W_DEFAULT,
    parameter int DEPTH_LOG2 = 4,
    parameter int GAP_CYCLES = 2,   // 1..255
    parameter int BLANK_ONLY = 1
) (
    input  logic                 i_pix_clk,
    input  logic                 i_rst,
    canvas_cmd_issuer_if.slave   s_push,
    input  logic                 i_blank,
    input  logic                 i_flush,
    output logic                 o_cmd_clk,
    output logic [DATA_W-1:0]    o_cmd_data,
    output logic [DEPTH_LOG2:0]  o_level,
    output logic                 o_busy
);

    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYCLES - 1);
    localparam logic                 ANY_TIME = (BLANK_ONLY == 0);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [GAP_CNT_W-1:0] r_gap_cnt;
    logic [GAP_CNT_W-1:0] w_gap_cnt_nxt;
    logic                 r_cmd_clk;
    logic [DATA_W-1:0]    r_cmd_data;

    logic                 w_go;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [DATA_W-1:0]    w_head;

    canvas_cmd_issuer_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_cmd_fifo (
        .i_clk   (i_pix_clk),
        .i_rst   (i_rst),
        .i_wr    (s_push.valid),
        .i_data  (s_push.data),
        .i_rd    (w_pop),
        .i_flush (i_flush),
        .o_head  (w_head),
        .o_level (o_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Ready depends only on the registered level, never on a same-cycle pop.
    assign s_push.ready = ~w_full;

    // Uses the registered level: a word pushed this edge is issued next edge.
    assign w_go = ~w_empty & (i_blank | ANY_TIME);

    // ---------------- state register ----------------
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // ---------------- next-state logic ----------------
    // NOTE: every always_comb output gets a default first so no path through
    // the case leaves it unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_go) w_state_nxt = ST_STROBE;
            ST_STROBE: w_state_nxt = ST_GAP;
            ST_GAP:    if (r_gap_cnt == '0) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        w_pop         = 1'b0;
        w_gap_cnt_nxt = r_gap_cnt;
        unique case (r_state)
            ST_IDLE:   w_pop = w_go;
            ST_STROBE: w_gap_cnt_nxt = GAP_LOAD;
            ST_GAP:    if (r_gap_cnt != '0) w_gap_cnt_nxt = r_gap_cnt - 1'b1;
            default:   w_gap_cnt_nxt = '0;
        endcase
    end

    // Output and counter registers. The strobe is high only in the cycle after
    // a pop, i.e. exactly while the FSM sits in STROBE.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            r_cmd_clk  <= 1'b0;
            r_cmd_data <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_cmd_clk <= w_pop;
            r_gap_cnt <= w_gap_cnt_nxt;
            if (w_pop) r_cmd_data <= w_head;
        end
    end

    assign o_cmd_clk  = r_cmd_clk;
    assign o_cmd_data = r_cmd_data;
    assign o_busy     = (r_state != ST_IDLE) | ~w_empty;

endmodule : canvas_cmd_issuer

// File: tb/tb_canvas_cmd_issuer.sv
// ----------------------------------------------------------------------------
// tb_canvas_cmd_issuer
//   Self-checking bench for canvas_cmd_issuer (DATA_W=32, DEPTH_LOG2=4,
//   GAP_CYCLES=2, BLANK_ONLY=1). The reference model keeps the queued words in
//   a SV queue and tracks strobe timing as "the earliest edge at which the
//   next strobe may be issued", derived from the strobe period GAP_CYCLES+2.
// ----------------------------------------------------------------------------
module tb_canvas_cmd_issuer;

    localparam int DATA_W     = 32;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int GAP_CYCLES = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                blank;
    logic                flush;
    logic                cmd_clk;
    logic [DATA_W-1:0]   cmd_data;
    logic [DEPTH_LOG2:0] level;
    logic                busy;

    canvas_cmd_issuer_if #(.DATA_W(DATA_W)) push_if ();

    canvas_cmd_issuer #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .GAP_CYCLES (GAP_CYCLES),
        .BLANK_ONLY (1)
    ) dut (
        .i_pix_clk  (clk),
        .i_rst      (rst),
        .s_push     (push_if),
        .i_blank    (blank),
        .i_flush    (flush),
        .o_cmd_clk  (cmd_clk),
        .o_cmd_data (cmd_data),
        .o_level    (level),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] m_q[$];
    longint            m_edge      = 0;
    longint            m_next_ok   = 0;     // earliest edge allowed to issue
    longint            m_last_iss  = -100;  // edge of the most recent issue
    logic [DATA_W-1:0] m_last_data = '0;

    function automatic void model_edge(input logic v, input logic [DATA_W-1:0] d,
                                       input logic b, input logic f, input logic r);
        bit room;
        m_edge++;
        if (r) begin
            m_q.delete();
            m_next_ok   = 0;
            m_last_iss  = -100;
            m_last_data = '0;
            return;
        end
        room = (m_q.size() != DEPTH);
        if (m_q.size() != 0 && b && m_edge >= m_next_ok) begin
            m_last_data = m_q.pop_front();
            m_last_iss  = m_edge;
            m_next_ok   = m_edge + GAP_CYCLES + 2;
        end
        if (f)              m_q.delete();
        else if (v && room) m_q.push_back(d);
    endfunction

    task automatic compare_all();
        check("cmd_clk",  cmd_clk,  m_last_iss == m_edge);
        check("cmd_data", cmd_data, m_last_data);
        check("level",    level,    m_q.size());
        check("ready",    push_if.ready, m_q.size() != DEPTH);
        check("busy",     busy, (m_q.size() != 0) || (m_edge - m_last_iss <= GAP_CYCLES));
    endtask

    // Drive inputs for one edge, advance the model, check #1 after the edge.
    task automatic step(input logic v, input logic [DATA_W-1:0] d,
                        input logic b, input logic f, input logic r);
        push_if.valid = v;
        push_if.data  = d;
        blank         = b;
        flush         = f;
        rst           = r;
        @(posedge clk);
        model_edge(v, d, b, f, r);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input logic b);
        for (int i = 0; i < n; i++) step(1'b0, '0, b, 1'b0, 1'b0);
    endtask

    int n_strobes;

    initial begin
        // ---- reset ----
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("rst_level", level, 0);
        check("rst_ready", push_if.ready, 1);
        check("rst_busy",  busy, 0);

        // ---- 1: single word, strobe 2 edges after push ----
        step(1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0);
        check("t1_no_early", cmd_clk, 0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t1_strobe", cmd_clk, 1);
        check("t1_data",   cmd_data, 32'hA5A5_0001);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t1_one_cycle", cmd_clk, 0);
        idle(4, 1'b1);

        // ---- 2: three back-to-back words ----
        for (int i = 0; i < 3; i++) step(1'b1, 32'h2000_0000 + i, 1'b1, 1'b0, 1'b0);
        n_strobes = 0;
        for (int i = 0; i < 14; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            if (cmd_clk) n_strobes++;
        end
        check("t2_strobes", n_strobes, 2);  // first one rose during the push burst
        check("t2_last", cmd_data, 32'h2000_0002);

        // ---- 3: held off while not blanked ----
        for (int i = 0; i < 5; i++) step(1'b1, 32'h3000_0000 + i, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        check("t3_level", level, 5);
        check("t3_busy",  busy, 1);
        idle(25, 1'b1);
        check("t3_drained", level, 0);

        // ---- 4: fill to 16, 17th refused, one blank cycle issues one word ----
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 32'h4000_0000 + i, 1'b0, 1'b0, 1'b0);
        check("t4_full_ready", push_if.ready, 0);
        check("t4_full_level", level, DEPTH);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t4_issue", cmd_clk, 1);
        check("t4_ready_back", push_if.ready, 1);
        idle(3, 1'b0);
        idle(70, 1'b1);
        check("t4_last", cmd_data, 32'h4000_000F);

        // ---- 5: flush on the edge a strobe rises with 4 words left ----
        for (int i = 0; i < 5; i++) step(1'b1, 32'h5000_0000 + i, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("t5_strobe", cmd_clk, 1);
        check("t5_level",  level, 0);
        n_strobes = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            if (cmd_clk) n_strobes++;
        end
        check("t5_no_more", n_strobes, 0);
        check("t5_idle", busy, 0);

        // ---- 6: reset during GAP with words queued ----
        for (int i = 0; i < 4; i++) step(1'b1, 32'h6000_0000 + i, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);   // issue
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);   // STROBE -> GAP
        step(1'b0, '0, 1'b1, 1'b1, 1'b1);   // reset (and flush) in GAP
        check("t6_data", cmd_data, 0);
        check("t6_level", level, 0);
        n_strobes = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            if (cmd_clk) n_strobes++;
        end
        check("t6_quiet", n_strobes, 0);

        // ---- randomized traffic ----
        begin
            logic b = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 19) == 0) b = ~b;
                step($urandom_range(0, 9) < 6, $urandom,
                     b, $urandom_range(0, 99) < 2, $urandom_range(0, 299) == 0);
            end
            idle(80, 1'b1);
            check("rand_drained", level, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_canvas_cmd_issuer
